// File: rtl/yarp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : yarp_pkg
// Description : Shared types and constants for the YARP instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package yarp_pkg;

    typedef enum logic [0:0] {
        RST_WAIT = 1'b0,
        RUN      = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/yarp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : yarp_sync_fifo
// Description : Single-clock FIFO with flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module yarp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop && !empty;
    // A full FIFO may still accept a write when the head leaves in the same cycle
    assign w_push_ok = push && (!full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/yarp_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : yarp_ifu_prefetch
// Description : Credit-based instruction prefetcher with in-order responses,
//               redirect flush and stale-response dropping.
// Revision    : 1.0 - initial release
// ============================================================================
module yarp_ifu_prefetch
    import yarp_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = c_reset_pc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rd_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int                c_cnt_w      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w:0]  c_depth      = (c_cnt_w + 1)'(FIFO_DEPTH);
    localparam logic [31:0]       c_start_pc   = RESET_PC & 32'hFFFF_FFFC;
    localparam int                c_entry_w    = $bits(fetch_entry_t);

    fetch_state_e         r_state;
    fetch_state_e         w_state_nxt;
    logic [31:0]          r_fetch_pc;
    logic [c_cnt_w-1:0]   r_drop_count;
    logic [c_cnt_w-1:0]   w_fifo_count;
    logic [c_cnt_w-1:0]   w_outstanding;
    logic [c_cnt_w:0]     w_credit_used;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pc_full;
    logic                 w_pc_empty;
    logic [31:0]          w_rsp_pc;
    logic                 w_req;
    logic                 w_hs;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_pc_pop;
    fetch_entry_t         w_push_entry;
    fetch_entry_t         w_head_entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffered entries plus in-flight requests must never exceed the buffer size
    assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, w_outstanding};

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            RST_WAIT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                w_req = (w_credit_used < c_depth) && !w_pc_full;
            end
            default: begin
                w_state_nxt = RST_WAIT;
            end
        endcase
    end

    assign w_hs     = w_req && mem_gnt_i;
    assign w_drop   = mem_rvalid_i && (r_drop_count != '0);
    assign w_push   = mem_rvalid_i && !w_drop && !redirect_i && !w_fifo_full;
    assign w_pop    = !w_fifo_empty && instr_ready_i && !redirect_i;
    assign w_pc_pop = mem_rvalid_i && !w_pc_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= c_start_pc;
        end else if (redirect_i) begin
            r_fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
        end else if (w_hs) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Everything still in flight at a redirect belongs to the old stream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (redirect_i) begin
            r_drop_count <= w_outstanding + c_cnt_w'(w_hs) - c_cnt_w'(mem_rvalid_i);
        end else if (w_drop) begin
            r_drop_count <= r_drop_count - c_cnt_w'(1);
        end
    end

    // Granted addresses in request order; its occupancy is the outstanding count
    yarp_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_hs),
        .pop   (w_pc_pop),
        .flush (1'b0),
        .wdata (r_fetch_pc),
        .rdata (w_rsp_pc),
        .full  (w_pc_full),
        .empty (w_pc_empty),
        .count (w_outstanding)
    );

    assign w_push_entry.pc    = w_rsp_pc;
    assign w_push_entry.instr = mem_rd_data_i;

    yarp_sync_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_entry_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_i),
        .wdata (w_push_entry),
        .rdata (w_head_entry),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign instr_mem_req_o  = w_req;
    assign instr_mem_addr_o = r_fetch_pc;
    assign instr_valid_o    = !w_fifo_empty;
    assign instr_o          = w_fifo_empty ? 32'h0 : w_head_entry.instr;
    assign instr_pc_o       = w_fifo_empty ? 32'h0 : w_head_entry.pc;

endmodule
`default_nettype wire

// File: tb/tb_yarp_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_yarp_ifu_prefetch
// Description : Self-checking bench for the prefetcher against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_yarp_ifu_prefetch;

    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_mem_req_o;
    logic [31:0] instr_mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rd_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    yarp_ifu_prefetch #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_mem_req_o  (instr_mem_req_o),
        .instr_mem_addr_o (instr_mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rd_data_i    (mem_rd_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: in-flight requests tagged with the stream epoch they
    // belong to, and the list of PCs the decoder should see, in order.
    logic [31:0] q_addr[$];
    int          q_cyc[$];
    int          q_ep[$];
    logic [31:0] bq[$];
    logic [31:0] exp_fetch;
    int          epoch;
    int          cyc;
    bit          running;
    int          n_gnt;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"},   32'(instr_mem_req_o), 32'h0);
        check({tag, "_addr"},  instr_mem_addr_o,     RESET_PC);
        check({tag, "_valid"}, 32'(instr_valid_o),   32'h0);
        check({tag, "_instr"}, instr_o,              32'h0);
        check({tag, "_pc"},    instr_pc_o,           32'h0);
    endtask

    task automatic model_reset();
        q_addr.delete();
        q_cyc.delete();
        q_ep.delete();
        bq.delete();
        exp_fetch = RESET_PC;
        epoch     = 0;
        running   = 1'b0;
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+2, update after edge
    task automatic step(input bit g, input bit rv_en, input bit rdy, input bit rd,
                        input logic [31:0] rpc);
        bit          rv;
        bit          hs;
        bit          pop;
        bit          req_s;
        bit          exp_req;
        logic [31:0] a;
        int          e;
        mem_gnt_i     = g;
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        rv = rv_en && (q_addr.size() > 0) && (q_cyc[0] < cyc);
        mem_rvalid_i  = rv;
        mem_rd_data_i = rv ? memf(q_addr[0]) : $urandom;
        #1;
        exp_req = running && ((bq.size() + q_addr.size()) < FIFO_DEPTH);
        check("req",   32'(instr_mem_req_o), 32'(exp_req));
        check("addr",  instr_mem_addr_o,     exp_fetch);
        check("valid", 32'(instr_valid_o),   32'(bq.size() > 0));
        if (bq.size() > 0) begin
            check("head_pc",    instr_pc_o, bq[0]);
            check("head_instr", instr_o,    memf(bq[0]));
        end
        req_s = instr_mem_req_o;
        pop   = (bq.size() > 0) && rdy && !rd;
        @(posedge clk);
        hs = req_s && g;
        if (pop) begin
            void'(bq.pop_front());
        end
        if (rv) begin
            a = q_addr.pop_front();
            void'(q_cyc.pop_front());
            e = q_ep.pop_front();
            if (e == epoch) begin
                bq.push_back(a);
            end
        end
        if (hs) begin
            q_addr.push_back(exp_fetch);
            q_cyc.push_back(cyc);
            q_ep.push_back(epoch);
            exp_fetch = exp_fetch + 32'd4;
            n_gnt++;
        end
        if (rd) begin
            epoch++;
            bq.delete();
            exp_fetch = {rpc[31:2], 2'b00};
        end
        running = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (((q_addr.size() > 0) || (bq.size() > 0)) && (i < 40)) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            i++;
        end
        check("drain_left", 32'(q_addr.size() + bq.size()), 32'h0);
    endtask

    task automatic do_async_reset();
        #2;
        reset         = 1'b1;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        #1;
        check_reset("r42_async");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("r42_hold");
        reset = 1'b0;
    endtask

    initial begin
        int          n0;
        bit          found;
        logic [31:0] a0;
        reset         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rd_data_i = 32'h0;
        instr_ready_i = 1'b0;
        cyc           = 0;
        n_gnt         = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst_state");
        reset = 1'b0;

        // Reset release, gnt tied high, one-cycle responses
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("r37_req_rise", 32'(instr_mem_req_o), 32'h1);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Back-pressure: decoder stalled
        n0 = n_gnt;
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("r38_grants",  32'(n_gnt - n0),       32'd4);
        check("r38_req_low", 32'(instr_mem_req_o), 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("r38_one_more", 32'(n_gnt - n0), 32'd5);
        drain();

        // Redirect with three requests in flight
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2002);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (instr_valid_o) begin
                check("r39_first_pc", instr_pc_o, 32'h0000_2000);
                found = 1'b1;
            end
        end
        check("r39_delivered", 32'(found), 32'h1);
        drain();

        // Redirect, grant, response and pop all in one cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3000);
        check("r40_empty", 32'(instr_valid_o), 32'h0);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        // Grant stall, then redirect to the top of the address space
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        a0 = instr_mem_addr_o;
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("r41_hold_addr", instr_mem_addr_o,      a0);
        check("r41_hold_req",  32'(instr_mem_req_o), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        check("r41_wrap_a", instr_mem_addr_o, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("r41_wrap_b", instr_mem_addr_o, 32'h0000_0000);
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Randomised traffic
        repeat (400) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4, $urandom);
        end

        // Reset in the middle of a burst
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        do_async_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("r42_resume_addr", instr_mem_addr_o,      RESET_PC);
        check("r42_resume_req",  32'(instr_mem_req_o), 32'h1);
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
